// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 block words, then streams W_0..W_63.
// Latency: W_0 valid the cycle after the 16th word is accepted; one word per handshake.
// Backpressure: w_ready_i=0 freezes w_o/t_o and the window; blk_valid_i gaps stall the load.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] blk_word_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] w_o,
  output logic [5:0]  t_o,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic        load_fire;
  logic        w_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_nxt   = state;
    blk_ready_o = 1'b0;
    w_valid_o   = 1'b0;
    done_o      = 1'b0;
    load_fire   = 1'b0;
    w_fire      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        blk_ready_o = 1'b1;
        load_fire   = blk_valid_i;
        if (load_fire && cnt == 4'd15) state_nxt = EXPAND;
      end
      EXPAND: begin
        w_valid_o = 1'b1;
        w_fire    = w_ready_i;
        if (w_fire && t == LAST_T) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load and round counters; both are held at zero while idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      t   <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
        t   <= '0;
      end else begin
        if (load_fire) cnt <= cnt + 4'd1;
        if (w_fire)    t   <= t + 6'd1;
      end
    end
  end

  // 16-word sliding window: written by index during load, shifted and extended per consumed word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load_fire) begin
      win[cnt] <= blk_word_i;
    end else if (w_fire) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end
  end

  assign w_o = win[0];
  assign t_o = t;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule with a queue scoreboard of model schedule words.
// Checks reset, load gaps, output stalls, ignored starts, mid-block reset and back-to-back blocks.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_sha256_msg_schedule;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] blk_word_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic [31:0] w_o;
  logic [5:0]  t_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic        done_o;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .blk_word_i  (blk_word_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .w_o         (w_o),
    .t_o         (t_o),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .done_o      (done_o)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] blk [16];
  logic [31:0] exp_q [$];
  logic [31:0] abc_ref [3];
  bit          abc_mode;
  bit          aborted;

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference schedule for the current block, queued in emission order
  task automatic push_model();
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"},  32'(blk_ready_o), 32'd0);
    chk({tag, "_vld"},  32'(w_valid_o),   32'd0);
    chk({tag, "_done"}, 32'(done_o),      32'd0);
    chk({tag, "_w"},    w_o,              32'd0);
    chk({tag, "_t"},    32'(t_o),         32'd0);
  endtask

  task automatic do_start();
    @(negedge CLK);
    chk("idle_done", 32'(done_o), 32'd0);
    chk("idle_rdy", 32'(blk_ready_o), 32'd0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Feed the 16 words; optional 3-cycle valid gap after word gap_after, optional start pulse
  task automatic load_block(input int gap_after, input bit pulse);
    push_model();
    for (int i = 0; i < 16; i++) begin
      chk("load_rdy", 32'(blk_ready_o), 32'd1);
      blk_valid_i = 1'b1;
      blk_word_i  = blk[i];
      start       = pulse && (i == 8);
      @(negedge CLK);
      blk_valid_i = 1'b0;
      start       = 1'b0;
      if (i == gap_after) begin
        blk_word_i = 32'hDEAD_BEEF;
        repeat (3) begin
          chk("gap_rdy", 32'(blk_ready_o), 32'd1);
          chk("gap_vld", 32'(w_valid_o), 32'd0);
          @(negedge CLK);
        end
      end
    end
    chk("load_end_rdy", 32'(blk_ready_o), 32'd0);
    chk("w0_latency_vld", 32'(w_valid_o), 32'd1);
  endtask

  // Consume the stream against the scoreboard; optional stall, start pulse or reset at given t
  task automatic run_expand(input int stall_at, input int pulse_at, input int rst_at,
                            output bit was_aborted);
    int idx     = 0;
    int stalled = 0;
    int cyc     = 0;
    was_aborted = 1'b0;
    while (idx < 64 && cyc < 300) begin
      cyc++;
      chk("w_vld", 32'(w_valid_o), 32'd1);
      chk("t_o", 32'(t_o), 32'(idx));
      chk("w_o", w_o, exp_q[0]);
      chk("no_early_done", 32'(done_o), 32'd0);
      if (abc_mode && idx >= 16 && idx <= 18) chk("abc_ref", w_o, abc_ref[idx-16]);
      if (idx == rst_at) begin
        RST = 1'b1;
        #1;
        check_zero("rst_async");
        exp_q.delete();
        was_aborted = 1'b1;
        @(negedge CLK);
        check_zero("rst_held");
        RST = 1'b0;
        return;
      end
      start = (idx == pulse_at);
      if (idx == stall_at && stalled < 5) begin
        w_ready_i = 1'b0;
        stalled++;
      end else begin
        w_ready_i = 1'b1;
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge CLK);
      start = 1'b0;
    end
    chk("word_count", 32'(idx), 32'd64);
    chk("end_vld", 32'(w_valid_o), 32'd0);
    chk("done_pulse", 32'(done_o), 32'd1);
  endtask

  initial begin
    RST         = 1'b1;
    start       = 1'b0;
    blk_valid_i = 1'b0;
    blk_word_i  = '0;
    w_ready_i   = 1'b1;
    abc_ref[0]  = 32'h6162_6380;
    abc_ref[1]  = 32'h000F_0000;
    abc_ref[2]  = 32'h7DA8_6405;
    #12;
    check_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    abc_mode = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;

    // abc block, continuous streaming
    do_start();
    load_block(-1, 1'b0);
    run_expand(-1, -1, -1, aborted);

    // valid gap after word 5
    do_start();
    load_block(5, 1'b0);
    run_expand(-1, -1, -1, aborted);

    // 5-cycle output stall at t=20
    do_start();
    load_block(-1, 1'b0);
    run_expand(20, -1, -1, aborted);

    // stray start pulses in LOAD and EXPAND
    do_start();
    load_block(-1, 1'b1);
    run_expand(-1, 10, -1, aborted);
    @(negedge CLK);
    chk("post_done_low", 32'(done_o), 32'd0);
    chk("post_vld_low", 32'(w_valid_o), 32'd0);
    chk("post_rdy_low", 32'(blk_ready_o), 32'd0);

    // reset at t=30, then the abc block again
    do_start();
    load_block(-1, 1'b0);
    run_expand(-1, -1, 30, aborted);
    repeat (3) begin
      chk("abort_no_done", 32'(done_o), 32'd0);
      chk("abort_idle_rdy", 32'(blk_ready_o), 32'd0);
      @(negedge CLK);
    end
    do_start();
    load_block(-1, 1'b0);
    run_expand(-1, -1, -1, aborted);

    // two random blocks back-to-back
    abc_mode = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      do_start();
      load_block(-1, 1'b0);
      run_expand(-1, -1, -1, aborted);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
